// File: rtl/fetch_stage.sv
// Fetch stage of the RV64 single-cycle CPU: owns the PC, registers each fetched word
// for the decoder, and handles stall, redirect, misaligned-target fault and EBREAK halt.
module fetch_stage #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter logic [31:0] EBREAK_WORD = 32'h00100073,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] pc,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    input  logic        resume,
    output logic        fetch_valid,
    output logic [63:0] fetch_pc,
    output logic [31:0] fetch_instruction,
    output logic [63:0] fetch_pc_plus4,
    output logic        misaligned_fault,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [63:0] r_pc;
    logic        r_fetch_valid;
    logic [63:0] r_fetch_pc;
    logic [31:0] r_fetch_instruction;
    logic [63:0] r_fetch_pc_plus4;
    logic        r_misaligned_fault;
    logic [31:0] r_fetch_count;

    logic [63:0] w_pc_plus4;
    logic        w_target_aligned;
    logic        w_is_ebreak;
    logic        w_capture;
    logic        w_take_redirect;
    logic        w_set_fault;
    logic        w_clr_fault;
    logic        w_clr_valid;

    assign w_pc_plus4       = r_pc + 64'd4;
    assign w_target_aligned = (redirect_target[1:0] == 2'b00);
    assign w_is_ebreak      = (instruction == EBREAK_WORD);

    // NOTE: non-blocking assignments for all registered state so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_capture       = 1'b0;
        w_take_redirect = 1'b0;
        w_set_fault     = 1'b0;
        w_clr_fault     = 1'b0;
        w_clr_valid     = 1'b0;

        unique case (r_state)
            ST_START: begin
                w_state_next = ST_RUN;
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    w_clr_valid = 1'b1;
                    if (w_target_aligned) begin
                        w_take_redirect = 1'b1;
                    end else begin
                        w_set_fault  = 1'b1;
                        w_state_next = ST_HALT;
                    end
                end else if (!stall) begin
                    // An EBREAK word is still delivered once before fetch stops.
                    w_capture = 1'b1;
                    if (w_is_ebreak) begin
                        w_state_next = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                if (!stall) begin
                    w_clr_valid = 1'b1;
                end
                if (resume) begin
                    w_clr_fault  = 1'b1;
                    w_state_next = ST_RUN;
                end
            end

            default: begin
                w_state_next = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (w_take_redirect) begin
            r_pc <= redirect_target;
        end else if (w_capture) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc          <= 64'h0;
            r_fetch_instruction <= NOP_WORD;
            r_fetch_pc_plus4    <= 64'd4;
            r_fetch_count       <= 32'h0;
        end else if (w_capture) begin
            r_fetch_pc          <= r_pc;
            r_fetch_instruction <= instruction;
            r_fetch_pc_plus4    <= w_pc_plus4;
            r_fetch_count       <= r_fetch_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_valid <= 1'b0;
        end else if (w_capture) begin
            r_fetch_valid <= 1'b1;
        end else if (w_clr_valid) begin
            r_fetch_valid <= 1'b0;
        end
    end

    // Sticky until an explicit resume out of HALT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_misaligned_fault <= 1'b0;
        end else if (w_set_fault) begin
            r_misaligned_fault <= 1'b1;
        end else if (w_clr_fault) begin
            r_misaligned_fault <= 1'b0;
        end
    end

    assign pc                = r_pc;
    assign fetch_valid       = r_fetch_valid;
    assign fetch_pc          = r_fetch_pc;
    assign fetch_instruction = r_fetch_instruction;
    assign fetch_pc_plus4    = r_fetch_pc_plus4;
    assign misaligned_fault  = r_misaligned_fault;
    assign halted            = (r_state == ST_HALT);
    assign fetch_count       = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios pinned with literal values,
// then randomized stall/redirect/resume traffic compared against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clk;
    logic        reset_n;
    logic [63:0] pc;
    logic [31:0] instruction;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        resume;
    logic        fetch_valid;
    logic [63:0] fetch_pc;
    logic [31:0] fetch_instruction;
    logic [63:0] fetch_pc_plus4;
    logic        misaligned_fault;
    logic        halted;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pc                (pc),
        .instruction       (instruction),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .resume            (resume),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_instruction (fetch_instruction),
        .fetch_pc_plus4    (fetch_pc_plus4),
        .misaligned_fault  (misaligned_fault),
        .halted            (halted),
        .fetch_count       (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: fixed words at the test addresses, hashed words elsewhere,
    // with an occasional EBREAK so random traffic also exercises halting.
    function automatic logic [31:0] mem(input logic [63:0] a);
        logic [31:0] w;
        case (a)
            64'h0:   w = 32'h00003083;
            64'h4:   w = 32'h00503103;
            64'h8:   w = 32'h021101B3;
            64'h14:  w = 32'h02428333;
            64'h20:  w = EBREAK;
            default: begin
                if (a[9:2] == 8'h5A) begin
                    w = EBREAK;
                end else begin
                    w = (a[31:0] * 32'h9E3779B9) ^ a[63:32] ^ 32'h13;
                    if (w == EBREAK) w = w ^ 32'h1;
                end
            end
        endcase
        return w;
    endfunction

    assign instruction = mem(pc);

    // Behavioural model of the fetch stage.
    logic        m_started;
    logic        m_halt;
    logic [63:0] m_pc;
    logic        m_valid;
    logic [63:0] m_fpc;
    logic [31:0] m_finstr;
    logic        m_fault;
    logic [31:0] m_count;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_started <= 1'b0;
            m_halt    <= 1'b0;
            m_pc      <= 64'h0;
            m_valid   <= 1'b0;
            m_fpc     <= 64'h0;
            m_finstr  <= NOP;
            m_fault   <= 1'b0;
            m_count   <= 32'h0;
        end else if (!m_started) begin
            m_started <= 1'b1;
        end else if (m_halt) begin
            if (!stall) m_valid <= 1'b0;
            if (resume) begin
                m_halt  <= 1'b0;
                m_fault <= 1'b0;
            end
        end else if (redirect_valid) begin
            m_valid <= 1'b0;
            if (redirect_target[1:0] == 2'b00) begin
                m_pc <= redirect_target;
            end else begin
                m_fault <= 1'b1;
                m_halt  <= 1'b1;
            end
        end else if (!stall) begin
            m_fpc    <= m_pc;
            m_finstr <= mem(m_pc);
            m_valid  <= 1'b1;
            m_count  <= m_count + 32'd1;
            m_pc     <= m_pc + 64'd4;
            m_halt   <= (mem(m_pc) == EBREAK);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("m.pc",      pc,                m_pc);
            check("m.valid",   64'(fetch_valid),  64'(m_valid));
            check("m.halted",  64'(halted),       64'(m_halt));
            check("m.fault",   64'(misaligned_fault), 64'(m_fault));
            check("m.count",   64'(fetch_count),  64'(m_count));
            if (m_valid) begin
                check("m.fpc",    fetch_pc,                m_fpc);
                check("m.finstr", 64'(fetch_instruction),  64'(m_finstr));
                check("m.plus4",  fetch_pc_plus4,          m_fpc + 64'd4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".pc"},     pc,                       64'h0);
        check({tag, ".valid"},  64'(fetch_valid),         64'h0);
        check({tag, ".fpc"},    fetch_pc,                 64'h0);
        check({tag, ".finstr"}, 64'(fetch_instruction),   64'(NOP));
        check({tag, ".plus4"},  fetch_pc_plus4,           64'h4);
        check({tag, ".fault"},  64'(misaligned_fault),    64'h0);
        check({tag, ".halted"}, 64'(halted),              64'h0);
        check({tag, ".count"},  64'(fetch_count),         64'h0);
    endtask

    initial begin
        reset_n         = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 64'h0;
        resume          = 1'b0;
        #1 reset_n = 1'b0;
        #2 check_reset_values("rst");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Sequential fetch from reset.
        tick();
        check("start.valid", 64'(fetch_valid), 64'h0);
        tick();
        check("f0.pc",    fetch_pc, 64'h0);
        check("f0.instr", 64'(fetch_instruction), 64'h00003083);
        check("f0.count", 64'(fetch_count), 64'd1);
        tick();
        check("f1.pc",    fetch_pc, 64'h4);
        check("f1.instr", 64'(fetch_instruction), 64'h00503103);
        check("f1.count", 64'(fetch_count), 64'd2);

        // Stall for three cycles.
        stall = 1'b1;
        repeat (3) tick();
        check("stall.pc",    pc, 64'h8);
        check("stall.fpc",   fetch_pc, 64'h4);
        check("stall.count", 64'(fetch_count), 64'd2);
        stall = 1'b0;
        tick();
        check("f2.pc",    fetch_pc, 64'h8);
        check("f2.instr", 64'(fetch_instruction), 64'h021101B3);
        check("f2.count", 64'(fetch_count), 64'd3);

        // Redirect overrides stall.
        redirect_valid  = 1'b1;
        redirect_target = 64'h14;
        stall           = 1'b1;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        check("redir.valid", 64'(fetch_valid), 64'h0);
        check("redir.pc",    pc, 64'h14);
        tick();
        check("redir.fpc",   fetch_pc, 64'h14);
        check("redir.instr", 64'(fetch_instruction), 64'h02428333);
        check("redir.plus4", fetch_pc_plus4, 64'h18);

        // Misaligned redirect faults and halts until resume.
        redirect_valid  = 1'b1;
        redirect_target = 64'h1A;
        tick();
        redirect_valid = 1'b0;
        check("mis.fault",  64'(misaligned_fault), 64'h1);
        check("mis.halted", 64'(halted), 64'h1);
        check("mis.valid",  64'(fetch_valid), 64'h0);
        check("mis.pc",     pc, 64'h18);
        redirect_valid  = 1'b1;
        redirect_target = 64'h40;
        tick();
        redirect_valid = 1'b0;
        check("halt.ignore_redir", pc, 64'h18);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("res.fault",  64'(misaligned_fault), 64'h0);
        check("res.halted", 64'(halted), 64'h0);
        tick();
        check("res.fpc",   fetch_pc, 64'h18);
        check("res.valid", 64'(fetch_valid), 64'h1);

        // EBREAK delivered once, then halt.
        redirect_valid  = 1'b1;
        redirect_target = 64'h20;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("ebk.fpc",    fetch_pc, 64'h20);
        check("ebk.instr",  64'(fetch_instruction), 64'(EBREAK));
        check("ebk.valid",  64'(fetch_valid), 64'h1);
        check("ebk.halted", 64'(halted), 64'h1);
        check("ebk.pc",     pc, 64'h24);
        tick();
        check("ebk.valid2", 64'(fetch_valid), 64'h0);
        resume = 1'b1;
        tick();
        resume = 1'b0;

        // Wrap at the top of the address space.
        redirect_valid  = 1'b1;
        redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap.fpc",   fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap.plus4", fetch_pc_plus4, 64'h0);
        check("wrap.pc",    pc, 64'h0);

        // Asynchronous reset mid-cycle.
        #2 reset_n = 1'b0;
        #1 check_reset_values("arst");
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic, with one asynchronous reset partway through.
        for (int i = 0; i < 4000; i++) begin
            stall           = ($urandom_range(0, 99) < 30);
            redirect_valid  = ($urandom_range(0, 99) < 10);
            resume          = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 3) == 0)
                redirect_target = {$urandom, $urandom};
            else
                redirect_target = {52'h0, 12'($urandom_range(0, 1023) << 2)};
            if ($urandom_range(0, 3) == 0)
                redirect_target[1:0] = 2'($urandom_range(1, 3));
            if (i == 2000) begin
                #2 reset_n = 1'b0;
                #1 check("rnd.arst.pc", pc, 64'h0);
                @(negedge clk);
                reset_n = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
